pinwheel_hart_sched: RTL and testbench
======================================

Name: pinwheel_hart_sched

Overview:
- Parametrised hart scheduler and PC holder for the next-generation barrel-threaded pinwheel core.
- Owns one HPC per hart. Issues one ready hart per cycle to the fetch stage over a valid/ready handshake, and accepts next-HPC commits from execute, including cross-hart jumps and thread exit.
- Accepts external hart start and halt requests for debug.
- Replaces the fixed single-slot HPC rotation with a variable hart count and explicit per-hart state.

Parameters:
- NUM_HARTS, 8: number of harts; power of two, 2..256.
- HART_BITS, $clog2(NUM_HARTS): width of the hart-id field.
- PC_BITS, 24: PC field width; HPC = {8-bit hart field, PC_BITS pc}, zero-extended to 32.
- RESET_PC, 24'h400000: hart 0 PC after reset.

Ports:
- clock  in  1  global clock
- reset_n  in  1  asynchronous active-low reset
- issue_valid  out  1  issue_hpc holds a hart to fetch
- issue_ready  in  1  fetch accepts issue_hpc this edge
- issue_hpc  out  32  {hart, pc} to fetch
- commit_valid  in  1  execute returns a next HPC
- commit_hart  in  HART_BITS  hart retiring an instruction
- commit_hpc  in  32  next HPC; hart field may differ from commit_hart
- start_valid  in  1  external request to launch a hart
- start_hpc  in  32  hart and PC to launch
- start_ack  out  1  start accepted (1-cycle pulse)
- halt_mask  in  NUM_HARTS  level; bit set = hart may not be issued
- hart_busy  out  NUM_HARTS  hart state is not IDLE
- err_valid  out  1  sticky cross-hart collision flag
- err_hart  out  HART_BITS  hart that caused the first error
- retire_count  out  32  total commits accepted

Behaviour:
- Reset is asynchronous while reset_n is low.
  - Hart 0: READY at RESET_PC.
  - All other harts: IDLE, pc = 0.
  - issue_valid = 0, issue_hpc = 0, start_ack = 0, err_valid = 0, err_hart = 0, retire_count = 0.
  - Round-robin pointer = NUM_HARTS-1, so hart 0 is issued first.
- Per-hart states:
  - IDLE: no thread.
  - READY: pc valid, awaiting issue.
  - INFLIGHT: issued, awaiting commit.
  - HALTED: error stop; cleared only by start or reset.
- Issue:
  - When issue_valid == 0, or issue_valid && issue_ready at the edge, the scheduler selects the next hart after the pointer with state READY and halt_mask bit clear. Selection is round-robin with wrap.
  - If a hart is found: register issue_valid = 1 and issue_hpc = its HPC, set that hart to INFLIGHT, and move the pointer to it.
  - If no hart is found: issue_valid = 0; issue_hpc holds its previous value.
  - issue_valid && !issue_ready: issue_valid and issue_hpc hold stable.
  - A hart whose halt_mask bit rises after selection still issues.
- Commit is ignored unless commit_hart is INFLIGHT. When accepted, retire_count increments and wraps at 2^32. With t = commit_hpc hart field and p = commit_hpc pc field:
  - p == 0: commit_hart becomes IDLE (thread exit).
  - t == commit_hart: commit_hart becomes READY with pc = p.
  - t != commit_hart and t IDLE: commit_hart becomes IDLE; t becomes READY with pc = p (thread migrates).
  - t != commit_hart and t not IDLE, or t >= NUM_HARTS: commit_hart becomes HALTED. If err_valid is clear, set err_valid = 1 and err_hart = commit_hart.
- A committed hart becomes issuable on the next cycle, so the minimum issue-to-reissue spacing is 2 cycles.
- Start:
  - Accepted when the target hart is IDLE or HALTED, the target is < NUM_HARTS, the start pc is nonzero, and the same-cycle commit does not target that hart.
  - On acceptance the target becomes READY with the start pc and start_ack pulses on the next cycle.
  - Otherwise start is dropped and start_ack = 0.
  - Commit wins over start for the same hart in the same cycle.
- hart_busy is registered. It reflects the state after each edge.
- Reset mid-operation: all state returns to reset values immediately. Any in-flight commit arriving after reset is ignored, because its hart is not INFLIGHT.

Test Plan:
- Reset, issue_ready = 1, no commits -> issue_hpc = 0x00400000, issue_valid = 1 for one cycle, then issue_valid = 0; hart_busy = 8'h01.
- Start harts 1 and 2 at 0x100/0x200 and commit each issue with pc+4 -> issue order 0,1,2,0,1,2… with pcs incrementing by 4; retire_count increments once per commit.
- issue_ready = 0 for 3 cycles with issue_valid = 1 -> issue_hpc stable; the hart is issued exactly once after ready rises.
- Hart 0 commits commit_hpc = 0x03000040 with hart 3 IDLE -> hart 0 IDLE, hart 3 issued at pc 0x40; commit to busy hart 1 -> hart 0 HALTED, err_valid = 1, err_hart = 0.
- Same-cycle start and commit targeting idle hart 5 -> commit pc is taken, start_ack = 0; halt_mask[5] = 1 -> hart 5 never issued until cleared.
- Assert reset_n low while harts are INFLIGHT, then raise it and commit hart 0 -> commit ignored, retire_count = 0, hart 0 reissued at 0x00400000.

Source files
------------

// File: rtl/pinwheel_hart_sched_if.sv
// Issue, commit and start handshake bundle between the hart scheduler and the
// fetch/execute pipeline. The scheduler side uses the master modport.
interface pinwheel_hart_sched_if #(
  parameter int NUM_HARTS = 8,
  parameter int HART_BITS = $clog2(NUM_HARTS)
);
  logic                 issue_valid;
  logic                 issue_ready;
  logic [31:0]          issue_hpc;
  logic                 commit_valid;
  logic [HART_BITS-1:0] commit_hart;
  logic [31:0]          commit_hpc;
  logic                 start_valid;
  logic [31:0]          start_hpc;
  logic                 start_ack;

  modport master (
    output issue_valid, issue_hpc, start_ack,
    input  issue_ready, commit_valid, commit_hart, commit_hpc, start_valid, start_hpc
  );

  modport slave (
    input  issue_valid, issue_hpc, start_ack,
    output issue_ready, commit_valid, commit_hart, commit_hpc, start_valid, start_hpc
  );
endinterface

// File: rtl/pinwheel_hart_sched.sv
// Barrel-thread hart scheduler: holds one HPC per hart, issues READY harts
// round-robin to fetch, and applies commits, migrations, exits and starts.
module pinwheel_hart_sched #(
  parameter int                 NUM_HARTS = 8,
  parameter int                 HART_BITS = $clog2(NUM_HARTS),
  parameter int                 PC_BITS   = 24,
  parameter logic [PC_BITS-1:0] RESET_PC  = 24'h400000
) (
  input  logic                 clock,
  input  logic                 reset_n,
  pinwheel_hart_sched_if.master bus,
  input  logic [NUM_HARTS-1:0] halt_mask,
  output logic [NUM_HARTS-1:0] hart_busy,
  output logic                 err_valid,
  output logic [HART_BITS-1:0] err_hart,
  output logic [31:0]          retire_count
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_READY    = 2'd1,
    ST_INFLIGHT = 2'd2,
    ST_HALTED   = 2'd3
  } hart_state_t;

  hart_state_t          st_r [NUM_HARTS];
  hart_state_t          st_nx [NUM_HARTS];
  logic [PC_BITS-1:0]   pc_r [NUM_HARTS];
  logic [PC_BITS-1:0]   pc_nx [NUM_HARTS];
  logic [HART_BITS-1:0] ptr_r;
  logic                 issue_valid_r;
  logic [31:0]          issue_hpc_r;
  logic                 start_ack_r;
  logic                 err_valid_r;
  logic [HART_BITS-1:0] err_hart_r;
  logic [31:0]          retire_r;
  logic [NUM_HARTS-1:0] busy_r;

  logic [NUM_HARTS-1:0] eligible_s;
  logic                 advance_s;
  logic                 found_s;
  logic [HART_BITS-1:0] sel_s;

  logic [7:0]           c_tgt_s;
  logic [PC_BITS-1:0]   c_pc_s;
  logic                 c_tgt_ok_s;
  logic [HART_BITS-1:0] c_tgt_idx_s;
  logic                 commit_acc_s;
  logic                 c_exit_s;
  logic                 c_self_s;
  logic                 c_mig_s;
  logic                 err_set_s;

  logic [7:0]           s_tgt_s;
  logic [PC_BITS-1:0]   s_pc_s;
  logic                 s_tgt_ok_s;
  logic [HART_BITS-1:0] s_idx_s;
  logic                 s_block_s;
  logic                 start_acc_s;

  assign advance_s = !issue_valid_r || bus.issue_ready;

  // Harts that may be picked this cycle.
  always_comb begin
    for (int i = 0; i < NUM_HARTS; i++) begin
      eligible_s[i] = (st_r[i] == ST_READY) && !halt_mask[i];
    end
  end

  // Round-robin search starting just after the last issued hart, wrapping to it last.
  always_comb begin
    logic [HART_BITS-1:0] idx;
    found_s = 1'b0;
    sel_s   = ptr_r;
    idx     = ptr_r;
    for (int i = 1; i <= NUM_HARTS; i++) begin
      idx = ptr_r + HART_BITS'(i);
      if (!found_s && eligible_s[idx]) begin
        found_s = 1'b1;
        sel_s   = idx;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Commit and start decode; the hart field may name a hart beyond NUM_HARTS.
  always_comb begin
    c_tgt_s      = bus.commit_hpc[PC_BITS+7:PC_BITS];
    c_pc_s       = bus.commit_hpc[PC_BITS-1:0];
    c_tgt_ok_s   = ({1'b0, c_tgt_s} < 9'(NUM_HARTS));
    c_tgt_idx_s  = c_tgt_s[HART_BITS-1:0];
    commit_acc_s = bus.commit_valid && (st_r[bus.commit_hart] == ST_INFLIGHT);
    c_exit_s     = (c_pc_s == {PC_BITS{1'b0}});
    c_self_s     = c_tgt_ok_s && (c_tgt_idx_s == bus.commit_hart);
    c_mig_s      = c_tgt_ok_s && !c_self_s && (st_r[c_tgt_idx_s] == ST_IDLE);
    err_set_s    = commit_acc_s && !c_exit_s && !c_self_s && !c_mig_s;

    s_tgt_s      = bus.start_hpc[PC_BITS+7:PC_BITS];
    s_pc_s       = bus.start_hpc[PC_BITS-1:0];
    s_tgt_ok_s   = ({1'b0, s_tgt_s} < 9'(NUM_HARTS));
    s_idx_s      = s_tgt_s[HART_BITS-1:0];
    s_block_s    = commit_acc_s &&
                   ((bus.commit_hart == s_idx_s) || (c_tgt_ok_s && (c_tgt_idx_s == s_idx_s)));
    start_acc_s  = bus.start_valid && s_tgt_ok_s && !s_block_s &&
                   (s_pc_s != {PC_BITS{1'b0}}) &&
                   ((st_r[s_idx_s] == ST_IDLE) || (st_r[s_idx_s] == ST_HALTED));
  end

  // Per-hart next state: issue, then commit, then start (never the same hart).
  always_comb begin
    for (int i = 0; i < NUM_HARTS; i++) begin
      st_nx[i] = st_r[i];
      pc_nx[i] = pc_r[i];
    end
    if (advance_s && found_s) begin
      st_nx[sel_s] = ST_INFLIGHT;
    end else begin
      st_nx[sel_s] = st_r[sel_s];
    end
    if (commit_acc_s) begin
      if (c_exit_s) begin
        st_nx[bus.commit_hart] = ST_IDLE;
      end else if (c_self_s) begin
        st_nx[bus.commit_hart] = ST_READY;
        pc_nx[bus.commit_hart] = c_pc_s;
      end else if (c_mig_s) begin
        st_nx[bus.commit_hart] = ST_IDLE;
        st_nx[c_tgt_idx_s]     = ST_READY;
        pc_nx[c_tgt_idx_s]     = c_pc_s;
      end else begin
        st_nx[bus.commit_hart] = ST_HALTED;
      end
    end else begin
      st_nx[bus.commit_hart] = st_nx[bus.commit_hart];
    end
    if (start_acc_s) begin
      st_nx[s_idx_s] = ST_READY;
      pc_nx[s_idx_s] = s_pc_s;
    end else begin
      st_nx[s_idx_s] = st_nx[s_idx_s];
    end
  end

  // State, issue register, status and counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_HARTS; i++) begin
        st_r[i] <= (i == 0) ? ST_READY : ST_IDLE;
        pc_r[i] <= (i == 0) ? RESET_PC : {PC_BITS{1'b0}};
      end
      ptr_r         <= HART_BITS'(NUM_HARTS - 1);
      issue_valid_r <= 1'b0;
      issue_hpc_r   <= 32'd0;
      start_ack_r   <= 1'b0;
      err_valid_r   <= 1'b0;
      err_hart_r    <= {HART_BITS{1'b0}};
      retire_r      <= 32'd0;
      busy_r        <= NUM_HARTS'(1);
    end else begin
      for (int i = 0; i < NUM_HARTS; i++) begin
        st_r[i]   <= st_nx[i];
        pc_r[i]   <= pc_nx[i];
        busy_r[i] <= (st_nx[i] != ST_IDLE);
      end
      if (advance_s) begin
        if (found_s) begin
          issue_valid_r <= 1'b1;
          issue_hpc_r   <= 32'({8'(sel_s), pc_r[sel_s]});
          ptr_r         <= sel_s;
        end else begin
          issue_valid_r <= 1'b0;
        end
      end
      if (commit_acc_s) begin
        retire_r <= retire_r + 32'd1;
      end
      if (err_set_s && !err_valid_r) begin
        err_valid_r <= 1'b1;
        err_hart_r  <= bus.commit_hart;
      end
      start_ack_r <= start_acc_s;
    end
  end

  assign bus.issue_valid = issue_valid_r;
  assign bus.issue_hpc   = issue_hpc_r;
  assign bus.start_ack   = start_ack_r;
  assign hart_busy       = busy_r;
  assign err_valid       = err_valid_r;
  assign err_hart        = err_hart_r;
  assign retire_count    = retire_r;

endmodule

// File: tb/tb_pinwheel_hart_sched.sv
// Scoreboard bench for pinwheel_hart_sched: expected issue HPCs are queued as
// stimulus is driven and popped on every observed issue handshake.
module tb_pinwheel_hart_sched;
  localparam int NH = 8;
  localparam int HB = 3;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [NH-1:0] halt_mask;
  logic [NH-1:0] hart_busy;
  logic          err_valid;
  logic [HB-1:0] err_hart;
  logic [31:0]   retire_count;

  pinwheel_hart_sched_if #(.NUM_HARTS(NH)) bus ();

  pinwheel_hart_sched #(.NUM_HARTS(NH)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .bus          (bus),
    .halt_mask    (halt_mask),
    .hart_busy    (hart_busy),
    .err_valid    (err_valid),
    .err_hart     (err_hart),
    .retire_count (retire_count)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  bit          auto_commit;
  int          hs_count;
  int          exit_after;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // One clock: detect a handshake at the coming edge, score it, then let the
  // execute model answer with a commit once the edge has passed.
  task automatic cyc();
    logic        hs;
    logic [31:0] hpc;
    hs  = bus.issue_valid && bus.issue_ready;
    hpc = bus.issue_hpc;
    if (hs) begin
      hs_count++;
      if (exp_q.size() == 0) check_eq("issue_unexpected", 32'(exp_q.size()), 32'd1);
      else check_eq("issue_hpc", hpc, exp_q.pop_front());
    end
    @(posedge clock);
    @(negedge clock);
    bus.commit_valid = 1'b0;
    bus.start_valid  = 1'b0;
    if (hs && auto_commit) begin
      bus.commit_valid = 1'b1;
      bus.commit_hart  = hpc[24+HB-1:24];
      bus.commit_hpc   = (hs_count >= exit_after) ? 32'd0 : hpc + 32'd4;
    end
  endtask

  task automatic do_reset(input logic rdy);
    reset_n          = 1'b0;
    bus.issue_ready  = rdy;
    bus.commit_valid = 1'b0;
    bus.start_valid  = 1'b0;
    halt_mask        = '0;
    auto_commit      = 1'b0;
    hs_count         = 0;
    exit_after       = 1000;
    #1;
    check_eq("rst_valid", 32'(bus.issue_valid), 32'd0);
    check_eq("rst_hpc", bus.issue_hpc, 32'd0);
    check_eq("rst_ack", 32'(bus.start_ack), 32'd0);
    check_eq("rst_busy", 32'(hart_busy), 32'h01);
    check_eq("rst_err", {28'd0, err_valid, err_hart}, 32'd0);
    check_eq("rst_retire", retire_count, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic start(input logic [31:0] hpc);
    bus.start_valid = 1'b1;
    bus.start_hpc   = hpc;
  endtask

  task automatic commit(input logic [HB-1:0] hart, input logic [31:0] hpc);
    bus.commit_valid = 1'b1;
    bus.commit_hart  = hart;
    bus.commit_hpc   = hpc;
  endtask

  initial begin
    reset_n          = 1'b1;
    halt_mask        = '0;
    bus.issue_ready  = 1'b0;
    bus.commit_valid = 1'b0;
    bus.commit_hart  = '0;
    bus.commit_hpc   = 32'd0;
    bus.start_valid  = 1'b0;
    bus.start_hpc    = 32'd0;
    @(negedge clock);

    // Reset issue of hart 0 only.
    do_reset(1'b1);
    exp_q.push_back(32'h0040_0000);
    cyc();
    check_eq("t1_valid", 32'(bus.issue_valid), 32'd1);
    cyc();
    check_eq("t1_idle", 32'(bus.issue_valid), 32'd0);
    check_eq("t1_hold", bus.issue_hpc, 32'h0040_0000);
    check_eq("t1_busy", 32'(hart_busy), 32'h01);
    cyc();
    check_eq("t1_idle2", 32'(bus.issue_valid), 32'd0);
    check_eq("t1_drained", 32'(exp_q.size()), 32'd0);

    // Round robin over harts 0..2, third round exits each thread.
    do_reset(1'b1);
    auto_commit = 1'b1;
    exit_after  = 7;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(32'h0040_0000 + 32'(4 * k));
      exp_q.push_back(32'h0100_0100 + 32'(4 * k));
      exp_q.push_back(32'h0200_0200 + 32'(4 * k));
    end
    start(32'h0100_0100);
    cyc();
    check_eq("t2_ack1", 32'(bus.start_ack), 32'd1);
    start(32'h0200_0200);
    cyc();
    check_eq("t2_ack2", 32'(bus.start_ack), 32'd1);
    for (int n = 0; n < 40 && exp_q.size() != 0; n++) cyc();
    repeat (3) cyc();
    check_eq("t2_drained", 32'(exp_q.size()), 32'd0);
    check_eq("t2_retire", retire_count, 32'd9);
    check_eq("t2_busy", 32'(hart_busy), 32'h00);
    check_eq("t2_valid", 32'(bus.issue_valid), 32'd0);

    // Fetch back-pressure.
    do_reset(1'b0);
    exp_q.push_back(32'h0040_0000);
    cyc();
    for (int i = 0; i < 3; i++) begin
      check_eq("t3_stall_valid", 32'(bus.issue_valid), 32'd1);
      check_eq("t3_stall_hpc", bus.issue_hpc, 32'h0040_0000);
      cyc();
    end
    bus.issue_ready = 1'b1;
    cyc();
    check_eq("t3_after", 32'(bus.issue_valid), 32'd0);
    cyc();
    check_eq("t3_after2", 32'(bus.issue_valid), 32'd0);
    check_eq("t3_drained", 32'(exp_q.size()), 32'd0);

    // Migration, collision error, sticky error, start filtering.
    do_reset(1'b1);
    exp_q.push_back(32'h0040_0000);
    cyc();
    cyc();
    commit(3'd0, 32'h0300_0040);
    exp_q.push_back(32'h0300_0040);
    cyc();
    check_eq("t4_busy_mig", 32'(hart_busy), 32'h08);
    check_eq("t4_retire1", retire_count, 32'd1);
    cyc();
    cyc();
    start(32'h0000_0300);
    exp_q.push_back(32'h0000_0300);
    cyc();
    check_eq("t4_ack0", 32'(bus.start_ack), 32'd1);
    start(32'h0100_0100);
    exp_q.push_back(32'h0100_0100);
    cyc();
    cyc();
    commit(3'd0, 32'h0100_0008);
    cyc();
    check_eq("t4_err_valid", 32'(err_valid), 32'd1);
    check_eq("t4_err_hart", 32'(err_hart), 32'd0);
    check_eq("t4_busy_err", 32'(hart_busy), 32'h0B);
    check_eq("t4_retire2", retire_count, 32'd2);
    commit(3'd3, 32'h0100_0010);
    cyc();
    check_eq("t4_err_sticky", 32'(err_hart), 32'd0);
    check_eq("t4_retire3", retire_count, 32'd3);
    commit(3'd5, 32'h0500_0010);
    cyc();
    check_eq("t4_ignored", retire_count, 32'd3);
    start(32'h0600_0000);
    cyc();
    check_eq("t4_start_pc0", 32'(bus.start_ack), 32'd0);
    start(32'h0100_0500);
    cyc();
    check_eq("t4_start_busy", 32'(bus.start_ack), 32'd0);
    start(32'h0000_0500);
    exp_q.push_back(32'h0000_0500);
    cyc();
    check_eq("t4_restart", 32'(bus.start_ack), 32'd1);
    cyc();
    cyc();
    check_eq("t4_drained", 32'(exp_q.size()), 32'd0);

    // Commit beats start on idle hart 5; halt_mask holds it back.
    do_reset(1'b1);
    exp_q.push_back(32'h0040_0000);
    cyc();
    cyc();
    commit(3'd0, 32'h0500_0080);
    start(32'h0500_0900);
    halt_mask = 8'h20;
    cyc();
    check_eq("t5_ack", 32'(bus.start_ack), 32'd0);
    check_eq("t5_busy", 32'(hart_busy), 32'h20);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check_eq("t5_halted", 32'(bus.issue_valid), 32'd0);
    end
    halt_mask = 8'h00;
    exp_q.push_back(32'h0500_0080);
    cyc();
    cyc();
    check_eq("t5_drained", 32'(exp_q.size()), 32'd0);

    // Reset mid-operation, stale commit afterwards is ignored.
    do_reset(1'b1);
    commit(3'd0, 32'h0000_0444);
    exp_q.push_back(32'h0040_0000);
    cyc();
    check_eq("t6_retire", retire_count, 32'd0);
    cyc();
    check_eq("t6_retire2", retire_count, 32'd0);
    check_eq("t6_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
